// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scanner: state encoding,
// the blank pattern and the active-low hex glyph table.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // {g,f,e,d,c,b,a}, active-low, indexed by hex value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_e;

endpackage

// File: rtl/seg_scan_if.sv
// Datapath-side inputs and pin-side outputs of the display scanner.
interface seg_scan_if #(
  parameter int unsigned NUM_DIG = 4
);
  localparam int unsigned IDX_W = $clog2(NUM_DIG);

  logic                   digsel;
  logic                   qsec;
  logic [4*NUM_DIG-1:0]   value;
  logic [NUM_DIG-1:0]     dp_in;
  logic                   blank_lz;
  logic [NUM_DIG-1:0]     blink_mask;
  logic [NUM_DIG-1:0]     an;
  logic [6:0]             seg;
  logic                   dp;
  logic [IDX_W-1:0]       dig_idx;

  modport master (
    output digsel, qsec, value, dp_in, blank_lz, blink_mask,
    input  an, seg, dp, dig_idx
  );

  modport slave (
    input  digsel, qsec, value, dp_in, blank_lz, blink_mask,
    output an, seg, dp, dig_idx
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex digit to active-low seven-segment pattern.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_c_o
);

  assign seg_c_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan.sv
// Multiplexed common-anode display scanner with frame capture, one-cycle
// anti-ghost blanking, leading-zero suppression and per-digit blink.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIG     = 4,
  parameter int unsigned BLINK_QSECS = 2
) (
  input  logic       clk,
  input  logic       greset_n,
  seg_scan_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIG);
  localparam int unsigned QW    = $clog2(BLINK_QSECS + 1);

  state_e                      state_q, state_d;
  logic [IDX_W-1:0]            dig_idx_q, dig_idx_d;
  logic [NUM_DIG-1:0][3:0]     cap_val_q, cap_val_d;
  logic [NUM_DIG-1:0]          cap_dp_q, cap_dp_d;
  logic [QW-1:0]               qcnt_q, qcnt_d;
  logic                        blink_q, blink_d;
  logic [NUM_DIG-1:0]          an_q, an_d;
  logic [6:0]                  seg_q, seg_d;
  logic                        dp_q, dp_d;
  logic [NUM_DIG-1:0]          lz_dark;
  logic                        all_zero;
  logic                        wrap;
  logic [6:0]                  seg_dec_c;

  // Scan sequencing, frame capture on wrap to digit 0, blink timebase
  always_comb begin
    state_d   = state_q;
    dig_idx_d = dig_idx_q;
    cap_val_d = cap_val_q;
    cap_dp_d  = cap_dp_q;
    qcnt_d    = qcnt_q;
    blink_d   = blink_q;
    wrap      = (dig_idx_q == IDX_W'(NUM_DIG - 1));

    if (bus.digsel) begin
      state_d   = BLANK;
      dig_idx_d = wrap ? '0 : dig_idx_q + IDX_W'(1);
      if (wrap) begin
        cap_val_d = bus.value;
        cap_dp_d  = bus.dp_in;
      end
    end else if (state_q == BLANK) begin
      state_d = SHOW;
    end

    if (bus.qsec) begin
      if (qcnt_q == QW'(BLINK_QSECS - 1)) begin
        qcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        qcnt_d = qcnt_q + QW'(1);
      end
    end
  end

  // A digit is dark when it and every more-significant captured digit is zero
  always_comb begin
    lz_dark  = '0;
    all_zero = 1'b1;
    for (int i = int'(NUM_DIG) - 1; i > 0; i--) begin
      all_zero   = all_zero && (cap_val_d[i] == 4'h0);
      lz_dark[i] = bus.blank_lz && all_zero;
    end
  end

  seg7_decode u_dec (
    .hex_i   (cap_val_d[dig_idx_d]),
    .seg_c_o (seg_dec_c)
  );

  // Output registers are loaded from the next state so BLANK lands one edge after digsel
  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    if (state_d == SHOW) begin
      seg_d = seg_dec_c;
      dp_d  = ~cap_dp_d[dig_idx_d];
      if (!lz_dark[dig_idx_d] && !(blink_q && bus.blink_mask[dig_idx_d])) begin
        an_d[dig_idx_d] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge greset_n) begin
    if (!greset_n) begin
      state_q   <= BLANK;
      dig_idx_q <= IDX_W'(NUM_DIG - 1);
      cap_val_q <= '0;
      cap_dp_q  <= '0;
      qcnt_q    <= '0;
      blink_q   <= 1'b0;
      an_q      <= '1;
      seg_q     <= SEG_OFF;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      dig_idx_q <= dig_idx_d;
      cap_val_q <= cap_val_d;
      cap_dp_q  <= cap_dp_d;
      qcnt_q    <= qcnt_d;
      blink_q   <= blink_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.an      = an_q;
  assign bus.seg     = seg_q;
  assign bus.dp      = dp_q;
  assign bus.dig_idx = dig_idx_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a behavioural display model queues the
// expected BLANK/SHOW outputs for every scan strobe it drives.
module tb_seg_scan;

  localparam int unsigned NUM_DIG     = 4;
  localparam int unsigned BLINK_QSECS = 2;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } out_t;

  logic clk;
  logic greset_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  out_t exp_q[$];

  logic [6:0] hex_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int          m_idx;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_blink;
  int          m_qcnt;

  seg_scan_if #(.NUM_DIG(NUM_DIG)) bus ();

  seg_scan #(.NUM_DIG(NUM_DIG), .BLINK_QSECS(BLINK_QSECS)) dut (
    .clk      (clk),
    .greset_n (greset_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_idx = 3; m_val = '0; m_dp = '0; m_blink = 1'b0; m_qcnt = 0;
  endfunction

  function automatic void model_qsec();
    if (m_qcnt == int'(BLINK_QSECS) - 1) begin
      m_qcnt  = 0;
      m_blink = ~m_blink;
    end else begin
      m_qcnt++;
    end
  endfunction

  function automatic void model_adv();
    m_idx = (m_idx + 1) % int'(NUM_DIG);
    if (m_idx == 0) begin
      m_val = bus.value;
      m_dp  = bus.dp_in;
    end
  endfunction

  function automatic out_t exp_show();
    out_t       o;
    logic [3:0] d;
    logic       dark;
    d    = m_val[m_idx*4 +: 4];
    dark = 1'b0;
    if (bus.blank_lz && m_idx != 0) begin
      dark = 1'b1;
      for (int k = m_idx; k < int'(NUM_DIG); k++)
        if (m_val[k*4 +: 4] != 4'h0) dark = 1'b0;
    end
    o.an = 4'hF;
    if (!dark && !(m_blink && bus.blink_mask[m_idx])) o.an[m_idx] = 1'b0;
    o.seg = hex_seg[d];
    o.dp  = ~m_dp[m_idx];
    return o;
  endfunction

  function automatic out_t blank_out();
    out_t o;
    o.an = 4'hF; o.seg = 7'h7F; o.dp = 1'b1;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.an = bus.an; o.seg = bus.seg; o.dp = bus.dp;
    return o;
  endfunction

  // One digsel strobe (optionally with a coincident qsec), called at a negedge
  task automatic scan(input logic qs, output out_t ob, output out_t os, output logic [1:0] ix);
    bus.digsel = 1'b1;
    bus.qsec   = qs;
    if (qs) model_qsec();
    model_adv();
    exp_q.push_back(blank_out());
    exp_q.push_back(exp_show());
    @(posedge clk);
    @(negedge clk);
    bus.digsel = 1'b0;
    bus.qsec   = 1'b0;
    ob = sample();
    @(posedge clk);
    @(negedge clk);
    os = sample();
    ix = bus.dig_idx;
  endtask

  task automatic qsec_pulse();
    bus.qsec = 1'b1;
    model_qsec();
    @(posedge clk);
    @(negedge clk);
    bus.qsec = 1'b0;
  endtask

  task automatic test_reset();
    out_t e;
    greset_n = 1'b0;
    bus.digsel = 0; bus.qsec = 0; bus.value = 16'h0000; bus.dp_in = 4'h0;
    bus.blank_lz = 0; bus.blink_mask = 4'h0;
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.an !== 4'hF)   begin n_bad++; $display("FAIL reset_an got %h want f", bus.an); end
    n_cmp++; if (bus.seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg got %h want 7f", bus.seg); end
    n_cmp++; if (bus.dp !== 1'b1)   begin n_bad++; $display("FAIL reset_dp got %b want 1", bus.dp); end
    n_cmp++; if (bus.dig_idx !== 2'd3) begin n_bad++; $display("FAIL reset_idx got %0d want 3", bus.dig_idx); end
    greset_n = 1'b1;
    @(negedge clk);
    e = exp_show();
    n_cmp++; if (sample() !== e) begin n_bad++; $display("FAIL post_reset_show got %h want %h", sample(), e); end
    #2 greset_n = 1'b0;
    #1;
    n_cmp++; if (sample() !== blank_out() || bus.dig_idx !== 2'd3) begin
      n_bad++; $display("FAIL async_reset got %h idx %0d want %h idx 3", sample(), bus.dig_idx, blank_out());
    end
    @(negedge clk);
    greset_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_scan_order();
    out_t ob, os, e;
    logic [1:0] ix;
    logic [3:0] want_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bus.value = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      scan(1'b0, ob, os, ix);
      e = exp_q.pop_front(); n_cmp++;
      if (ob !== e) begin n_bad++; $display("FAIL order_blank got %h want %h", ob, e); end
      e = exp_q.pop_front(); n_cmp++;
      if (os !== e) begin n_bad++; $display("FAIL order_show got %h want %h", os, e); end
      n_cmp++;
      if (ix !== 2'(m_idx) || os.an !== want_an[i % 4]) begin
        n_bad++; $display("FAIL order_idx got %0d/%b want %0d/%b", ix, os.an, m_idx, want_an[i % 4]);
      end
    end
  endtask

  task automatic test_frame();
    out_t ob, os, e;
    logic [1:0] ix;
    logic [6:0] want_seg [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h0E};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.value = 16'hFFFF;
      scan(1'b0, ob, os, ix);
      e = exp_q.pop_front(); n_cmp++;
      if (ob !== e) begin n_bad++; $display("FAIL frame_blank got %h want %h", ob, e); end
      e = exp_q.pop_front(); n_cmp++;
      if (os !== e || os.seg !== want_seg[i]) begin
        n_bad++; $display("FAIL frame_show got %h want %h seg %h", os, e, want_seg[i]);
      end
    end
    repeat (3) begin
      scan(1'b0, ob, os, ix);
      void'(exp_q.pop_front());
      e = exp_q.pop_front();
    end
  endtask

  task automatic test_lead_zero();
    out_t ob, os, e;
    logic [1:0] ix;
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0000};
    logic        lz   [3] = '{1'b1, 1'b1, 1'b0};
    for (int c = 0; c < 3; c++) begin
      bus.value = vals[c];
      bus.blank_lz = lz[c];
      for (int i = 0; i < 8; i++) begin
        scan(1'b0, ob, os, ix);
        e = exp_q.pop_front(); n_cmp++;
        if (ob !== e) begin n_bad++; $display("FAIL lz_blank cfg %0d got %h want %h", c, ob, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (os !== e) begin n_bad++; $display("FAIL lz_show cfg %0d idx %0d got %h want %h", c, m_idx, os, e); end
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_blink();
    out_t ob, os, e;
    logic [1:0] ix;
    bus.value = 16'h1234;
    bus.blink_mask = 4'b0001;
    for (int ph = 0; ph < 3; ph++) begin
      if (ph < 2) begin
        qsec_pulse();
        qsec_pulse();
      end
      for (int i = 0; i < 5; i++) begin
        scan(ph == 2 && i < 2, ob, os, ix);
        e = exp_q.pop_front(); n_cmp++;
        if (ob !== e) begin n_bad++; $display("FAIL blink_blank ph %0d got %h want %h", ph, ob, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (os !== e) begin n_bad++; $display("FAIL blink_show ph %0d idx %0d got %h want %h", ph, m_idx, os, e); end
      end
    end
    bus.blink_mask = 4'b0000;
  endtask

  task automatic test_dp();
    out_t ob, os, e;
    logic [1:0] ix;
    bus.value = 16'h8888;
    bus.dp_in = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      scan(1'b0, ob, os, ix);
      e = exp_q.pop_front(); n_cmp++;
      if (ob !== e) begin n_bad++; $display("FAIL dp_blank got %h want %h", ob, e); end
      e = exp_q.pop_front(); n_cmp++;
      if (os !== e || os.dp !== (m_idx != 2)) begin
        n_bad++; $display("FAIL dp_show idx %0d got %h want %h", m_idx, os, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_t o1, o2, o3, e;
    bus.digsel = 1'b1;
    model_adv();
    @(posedge clk);
    @(negedge clk);
    o1 = sample();
    model_adv();
    @(posedge clk);
    @(negedge clk);
    bus.digsel = 1'b0;
    o2 = sample();
    e = exp_show();
    @(posedge clk);
    @(negedge clk);
    o3 = sample();
    n_cmp++; if (o1 !== blank_out()) begin n_bad++; $display("FAIL b2b_blank1 got %h want %h", o1, blank_out()); end
    n_cmp++; if (o2 !== blank_out()) begin n_bad++; $display("FAIL b2b_blank2 got %h want %h", o2, blank_out()); end
    n_cmp++; if (o3 !== e || bus.dig_idx !== 2'(m_idx)) begin
      n_bad++; $display("FAIL b2b_show got %h idx %0d want %h idx %0d", o3, bus.dig_idx, e, m_idx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan_order();
    test_frame();
    test_lead_zero();
    test_blink();
    test_dp();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Consumes the `digsel` scan strobe and `qsec` quarter-second strobe produced by the clock block.
- Time-multiplexes a `NUM_DIG`-digit common-anode seven-segment display.
- Provides per-digit hex decode, frame-coherent value capture, anti-ghost blanking, optional leading-zero suppression and per-digit blinking.
- Sits between the datapath and the top-level `an`/`seg`/`dp` pins.

Parameters:
NUM_DIG, 4, number of multiplexed digits (2..8)
BLINK_QSECS, 2, qsec pulses per blink half-period (2 gives 0.5 s on / 0.5 s off)

Ports:
clk  input  1  system clock (the clock block's `clk` output)
greset_n  input  1  asynchronous active-low reset
digsel  input  1  one-`clk`-cycle scan strobe; advances to the next digit
qsec  input  1  one-`clk`-cycle quarter-second strobe
value  input  4*NUM_DIG  hex digits; digit i = value[4i+3:4i], digit 0 rightmost
dp_in  input  NUM_DIG  decimal point request per digit, active-high
blank_lz  input  1  1 = suppress leading zeros
blink_mask  input  NUM_DIG  1 = digit blinks; sampled live, not captured
an  output  NUM_DIG  anode enables, active-low, registered
seg  output  7  {g,f,e,d,c,b,a}, active-low, registered
dp  output  1  decimal point, active-low, registered
dig_idx  output  $clog2(NUM_DIG)  index of the digit currently selected

Behaviour:
- Reset (async, on greset_n low, immediate):
  - an = all 1s, seg = 7'h7F, dp = 1.
  - dig_idx = NUM_DIG-1, state = BLANK.
  - blink_phase = 0, qsec counter = 0.
  - Captured value and dp = 0.
- FSM, two states:
  - SHOW: `an` drives the selected digit. On digsel: dig_idx <= (dig_idx+1) mod NUM_DIG, go to BLANK.
  - BLANK: an = all 1s, seg = 7'h7F, dp = 1 for exactly one cycle, then SHOW.
  - digsel arriving in BLANK advances dig_idx again and stays in BLANK one more cycle.
- Latency: digsel at cycle t gives an all-off at t+1; new digit on an/seg/dp at t+2.
- Frame capture: when dig_idx advances to 0, value and dp_in are captured in the same edge. The first digsel after reset therefore captures.
  - Input changes mid-frame are invisible until the next wrap; there is no tearing.
- Decode: hex 0-F, standard patterns, e.g.:
  - 0 = 7'h40, 1 = 7'h79, 3 = 7'h30, 4 = 7'h19, 5 = 7'h12, 8 = 7'h00, F = 7'h0E.
- Leading-zero suppression (blank_lz = 1):
  - Digit i (i > 0) is dark (its `an` stays 1) when captured digits NUM_DIG-1 down to i are all 0.
  - Digit 0 is never suppressed; a value of 0 shows a single "0".
  - blank_lz is sampled live.
- Blink:
  - The qsec counter increments on qsec. When it reaches BLINK_QSECS-1 and qsec is high, it clears and blink_phase toggles.
  - While blink_phase = 1, a selected digit with blink_mask bit set keeps `an` high; seg and dp are unaffected.
- Simultaneous events: digsel and qsec in the same cycle are both processed; they are independent.
- dp = ~captured_dp[dig_idx] in SHOW, 1 in BLANK.
- All outputs come from flops; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package `seg_pkg` holds:
  - `SEG_OFF` = 7'h7F.
  - The 16-entry hex-to-segment constant table.
  - The state typedef {SHOW, BLANK}.
- One sub-module is natural: `seg7_decode`, a combinational 4-bit to 7-bit active-low decoder.
- Scan, capture, blink and output registers stay in `seg_scan`.

Test Plan:
- Reset check: hold greset_n = 0 → an = 4'hF, seg = 7'h7F, dp = 1, dig_idx = 3. Assert reset asynchronously mid-SHOW → outputs return to reset values without a clk edge.
- Scan order: value = 16'h1234, digsel every 16 cycles starting at t.
  - t+1: an = 4'hF.
  - t+2: an = 4'b1110, seg = 7'h19.
  - Next digsel +2: an = 4'b1101, seg = 7'h30.
  - Full cycle 1110 → 1101 → 1011 → 0111 → 1110, with a one-cycle all-off before each.
- Frame coherence: change value to 16'hFFFF while dig_idx = 1 → digits 2 and 3 still show 2 and 1. After the wrap to 0, digit 0 shows seg = 7'h0E.
- Leading zeros: blank_lz = 1.
  - value = 16'h0005: an bits 3..1 never go low; digit 0 seg = 7'h12.
  - value = 16'h0000: only digit 0 lit, seg = 7'h40.
  - blank_lz = 0 with value = 16'h0000: all four digits lit with 7'h40.
- Blink: BLINK_QSECS = 2, blink_mask = 4'b0001.
  - After 2 qsec pulses, an[0] stays 1 during digit 0's slot while digits 1-3 scan normally.
  - After 2 more qsec pulses, digit 0 is lit again.
  - A qsec coincident with digsel still counts.
- Decimal point: dp_in = 4'b0100, value = 16'h8888 → dp = 0 only during digit 2's SHOW slot (with seg = 7'h00); dp = 1 in every BLANK cycle.
